fir_output_stage: RTL and testbench
===================================

# fir_output_stage

Sink-side companion to the FIR sample-period counter. Captures the filter's accumulator result on each single-cycle output strobe and buffers it in a small FIFO. Presents results to downstream logic over a valid/ready handshake and flags overruns when downstream stalls. Sits between the FIR datapath/strobe counter and the system output interface.

## Interface
Parameters:
- DATA_W, 16, width of FIR result and output data
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 8, width of saturating drop counter

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- sample_strobe  input  1  single-cycle capture enable from the sample-period counter
- fir_data  input  DATA_W  FIR accumulator result; valid in cycles where sample_strobe=1
- out_data  output  DATA_W  head-of-FIFO sample
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  downstream accepts out_data this cycle
- level  output  $clog2(DEPTH)+1  current number of stored samples
- overflow  output  1  sticky flag, set when a strobe is dropped
- drop_count  output  CNT_W  saturating count of dropped strobes
- overflow_clr  input  1  synchronous clear of overflow and drop_count

## Operation
- Push: rising edge with sample_strobe=1 writes fir_data at the tail if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
- Pop: rising edge with out_valid=1 and out_ready=1 advances the head.
- Drop: strobe while level==DEPTH and no pop. Sample is discarded, overflow is set, and drop_count increments and saturates at all-ones.
- A strobe held high for multiple cycles is a push every cycle. No edge detection.
- Push and pop in the same cycle: level is unchanged and both pointers advance. When empty, only the push takes effect, because out_valid=0 blocks the pop.
- overflow_clr clears overflow and drop_count. If a drop coincides with the clear, the drop wins: overflow=1 and drop_count=1.
- out_valid = (level != 0). out_data is the head entry and stays stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately to distinguish full from empty.
- Reset (reset=0, any time, including mid-transfer) immediately clears pointers, level, overflow and drop_count. Outputs: out_valid=0, out_data=0, level=0, overflow=0, drop_count=0. Storage contents are don't-care.

## Timing
- Strobe-to-valid latency is 1 cycle. A strobe sampled at edge N into an empty FIFO gives out_valid=1 and out_data=fir_data after edge N.
- Pop-to-next latency is 0 extra cycles. The next entry appears on out_data after the accepting edge.
- level, overflow and drop_count update on the same edge as the push, pop or drop that changes them.
- Sustained throughput is one push and one pop per cycle.
- out_valid must not depend combinationally on out_ready.
- On reset deassertion, the first edge with reset=1 is a normal operating edge.

## Structure
- A shared package `fir_pkg` holds the DATA_W default, the DEPTH default, and the localparam for pointer width ($clog2(DEPTH)).
- Sub-module `fir_out_fifo` contains storage, pointers and level, with push/pop/full/empty ports.
- The top level keeps the drop/overflow logic and the handshake mapping.

## Test plan
- Single sample: after reset, strobe with fir_data=16'h1234, out_ready=1. Required: out_valid=1 for one cycle with out_data=16'h1234, then out_valid=0 and level=0.
- Backpressure fill: out_ready=0, strobes with data 1,2,3,4. Required: level=4 and out_data=1 stable. Then out_ready=1: data 1,2,3,4 emitted in order on consecutive cycles.
- Overflow: full with out_ready=0, 3 more strobes. Required: overflow=1, drop_count=3, stored data unchanged. After overflow_clr pulse: overflow=0, drop_count=0.
- Simultaneous push/pop when full: level=4, out_ready=1, strobe with data 5. Required: level stays 4, overflow stays 0, data 5 emitted last.
- Periodic operation: strobe every 16 cycles for 100 periods, out_ready=1. Required: level never exceeds 1, and output sequence equals input sequence.
- Mid-operation reset: level=3, assert reset=0 between edges. Required: out_valid, level and drop_count go to 0 immediately. After release, the first strobe is output with 1-cycle latency.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults for the FIR output stage: data width, FIFO depth, counter width.
package fir_pkg;

   localparam int unsigned FIR_DATA_W = 16;
   localparam int unsigned FIR_DEPTH  = 4;
   localparam int unsigned FIR_CNT_W  = 8;
   localparam int unsigned FIR_PTR_W  = $clog2(FIR_DEPTH);

endpackage

// File: rtl/fir_output_stage_if.sv
// Capture/handshake/status bundle between the FIR datapath, the output stage and downstream.
interface fir_output_stage_if
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = FIR_DATA_W,
   parameter int unsigned DEPTH  = FIR_DEPTH,
   parameter int unsigned CNT_W  = FIR_CNT_W
);

   logic                     sample_strobe;
   logic [DATA_W-1:0]        fir_data;
   logic [DATA_W-1:0]        out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   level;
   logic                     overflow;
   logic [CNT_W-1:0]         drop_count;
   logic                     overflow_clr;

   // Environment side: produces samples, consumes results and status.
   modport master (
      output sample_strobe, fir_data, out_ready, overflow_clr,
      input  out_data, out_valid, level, overflow, drop_count
   );

   // Output stage side.
   modport slave (
      input  sample_strobe, fir_data, out_ready, overflow_clr,
      output out_data, out_valid, level, overflow, drop_count
   );

endinterface

// File: rtl/fir_out_fifo.sv
// Small power-of-two FIFO with explicit level tracking and a registered head output.
module fir_out_fifo
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = FIR_DATA_W,
   parameter int unsigned DEPTH  = FIR_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic [DATA_W-1:0]       push_data_i,
   output logic [DATA_W-1:0]       head_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   // Next pointers/level; head is precomputed so out_data comes straight from a flop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = '0;

      if (push_i) wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (pop_i)  rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));

      case ({push_i, pop_i})
         2'b10:   level_d = LVL_W'(level_q + LVL_W'(1));
         2'b01:   level_d = LVL_W'(level_q - LVL_W'(1));
         default: level_d = level_q;
      endcase

      // New head is the incoming sample when it lands exactly at the next read slot.
      if (level_d != '0) begin
         if (push_i && (wr_ptr_q == rd_ptr_d)) head_d = push_data_i;
         else                                  head_d = mem_q[rd_ptr_d];
      end

      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
   end

   // Control state with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Sample storage; contents after reset are don't-care.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = head_q;
   assign level_o = level_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/fir_output_stage.sv
// FIR result capture: buffers strobed samples, drives valid/ready, counts overruns.
module fir_output_stage
   import fir_pkg::*;
#(
   parameter int unsigned DATA_W = FIR_DATA_W,
   parameter int unsigned DEPTH  = FIR_DEPTH,
   parameter int unsigned CNT_W  = FIR_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   fir_output_stage_if.slave  bus
);

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic              push;
   logic              pop;
   logic              drop;
   logic              full;
   logic              empty;
   logic [LVL_W-1:0]  level;
   logic [DATA_W-1:0] head;
   logic              overflow_q, overflow_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   // A full FIFO still accepts a strobe when the head leaves on the same edge.
   assign pop  = ~empty & bus.out_ready;
   assign push = bus.sample_strobe & (~full | pop);
   assign drop = bus.sample_strobe & full & ~pop;

   fir_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (bus.fir_data),
      .head_o      (head),
      .level_o     (level),
      .full_o      (full),
      .empty_o     (empty)
   );

   // Overrun tracking; a drop coinciding with a clear restarts the count at one.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (bus.overflow_clr)       drop_cnt_d = CNT_W'(1);
         else if (drop_cnt_q != '1) drop_cnt_d = CNT_W'(drop_cnt_q + CNT_W'(1));
      end else if (bus.overflow_clr) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   // Overrun state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.out_data   = head;
   assign bus.out_valid  = ~empty;
   assign bus.level      = level;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_cnt_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Directed bench for fir_output_stage: capture, backpressure, overrun, periodic flow, reset.
module tb_fir_output_stage;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CNT_W  = 8;

   logic clk = 1'b0;
   logic reset;

   fir_output_stage_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   fir_output_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push n samples base, base+1, ... with downstream stalled.
   task automatic fill(input logic [15:0] base, input int n);
      bus.out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.sample_strobe = 1'b1;
         bus.fir_data      = 16'(base + 16'(i));
         tick();
      end
      bus.sample_strobe = 1'b0;
   endtask

   task automatic clr_pulse();
      bus.overflow_clr = 1'b1;
      tick();
      bus.overflow_clr = 1'b0;
   endtask

   initial begin
      int unsigned max_lvl;
      logic [15:0] d;

      reset             = 1'b0;
      bus.sample_strobe = 1'b0;
      bus.fir_data      = '0;
      bus.out_ready     = 1'b0;
      bus.overflow_clr  = 1'b0;
      repeat (2) tick();

      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      chk("rst_level", 32'(bus.level),     32'd0);
      chk("rst_ovf",   32'(bus.overflow),  32'd0);
      chk("rst_drops", 32'(bus.drop_count), 32'd0);
      reset = 1'b1;

      // Single sample, one-cycle latency, immediately consumed
      bus.out_ready     = 1'b1;
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'h1234;
      tick();
      bus.sample_strobe = 1'b0;
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_data",  32'(bus.out_data),  32'h1234);
      chk("single_level", 32'(bus.level),     32'd1);
      tick();
      chk("single_valid_after", 32'(bus.out_valid), 32'd0);
      chk("single_level_after", 32'(bus.level),     32'd0);

      // Backpressure fill then in-order drain
      fill(16'd1, 4);
      chk("bp_level", 32'(bus.level),    32'd4);
      chk("bp_head",  32'(bus.out_data), 32'd1);
      tick();
      chk("bp_head_stable", 32'(bus.out_data), 32'd1);
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_drain_data",  32'(bus.out_data),  32'(k));
         tick();
      end
      chk("bp_empty_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_empty_level", 32'(bus.level),     32'd0);

      // Overflow: three drops on a full stalled FIFO
      fill(16'd1, 4);
      for (int i = 0; i < 3; i++) begin
         bus.sample_strobe = 1'b1;
         bus.fir_data      = 16'(16'hAA00 + 16'(i));
         tick();
      end
      bus.sample_strobe = 1'b0;
      chk("ovf_flag",  32'(bus.overflow),   32'd1);
      chk("ovf_drops", 32'(bus.drop_count), 32'd3);
      chk("ovf_level", 32'(bus.level),      32'd4);
      chk("ovf_head",  32'(bus.out_data),   32'd1);
      clr_pulse();
      chk("clr_flag",  32'(bus.overflow),   32'd0);
      chk("clr_drops", 32'(bus.drop_count), 32'd0);

      // Drop coinciding with clear: drop wins
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'hDEAD;
      bus.overflow_clr  = 1'b1;
      tick();
      bus.sample_strobe = 1'b0;
      bus.overflow_clr  = 1'b0;
      chk("clrdrop_flag",  32'(bus.overflow),   32'd1);
      chk("clrdrop_drops", 32'(bus.drop_count), 32'd1);
      chk("clrdrop_head",  32'(bus.out_data),   32'd1);
      clr_pulse();

      // Push and pop together while full
      bus.out_ready     = 1'b1;
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'd5;
      tick();
      bus.sample_strobe = 1'b0;
      chk("pp_level", 32'(bus.level),    32'd4);
      chk("pp_ovf",   32'(bus.overflow), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         chk("pp_drain_data", 32'(bus.out_data), 32'(k));
         tick();
      end
      chk("pp_empty_valid", 32'(bus.out_valid), 32'd0);

      // Drop counter saturates at all-ones
      fill(16'd10, 4);
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'h7777;
      repeat (300) tick();
      bus.sample_strobe = 1'b0;
      chk("sat_drops", 32'(bus.drop_count), 32'd255);
      chk("sat_flag",  32'(bus.overflow),   32'd1);
      chk("sat_head",  32'(bus.out_data),   32'd10);
      bus.out_ready = 1'b1;
      repeat (4) tick();
      clr_pulse();
      chk("sat_drain_level", 32'(bus.level),      32'd0);
      chk("sat_clr_drops",   32'(bus.drop_count), 32'd0);

      // Periodic strobe every 16 cycles with downstream always ready
      max_lvl = 0;
      for (int p = 0; p < 100; p++) begin
         d = 16'(16'(p) * 16'h0137 + 16'h0100);
         bus.sample_strobe = 1'b1;
         bus.fir_data      = d;
         tick();
         bus.sample_strobe = 1'b0;
         chk("per_data", 32'(bus.out_data), 32'(d));
         if (32'(bus.level) > max_lvl) max_lvl = 32'(bus.level);
         repeat (15) begin
            tick();
            if (32'(bus.level) > max_lvl) max_lvl = 32'(bus.level);
         end
      end
      chk("per_max_level", max_lvl, 32'd1);
      chk("per_end_valid", 32'(bus.out_valid), 32'd0);

      // Asynchronous reset mid-operation with level 3 and a recorded drop
      fill(16'd20, 4);
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'h0BAD;
      tick();
      bus.sample_strobe = 1'b0;
      bus.out_ready     = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("mr_pre_level", 32'(bus.level),      32'd3);
      chk("mr_pre_drops", 32'(bus.drop_count), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_valid", 32'(bus.out_valid),  32'd0);
      chk("mr_level", 32'(bus.level),      32'd0);
      chk("mr_drops", 32'(bus.drop_count), 32'd0);
      chk("mr_ovf",   32'(bus.overflow),   32'd0);
      chk("mr_data",  32'(bus.out_data),   32'd0);
      #1;
      reset             = 1'b1;
      bus.sample_strobe = 1'b1;
      bus.fir_data      = 16'hBEEF;
      tick();
      bus.sample_strobe = 1'b0;
      chk("mr_post_valid", 32'(bus.out_valid), 32'd1);
      chk("mr_post_data",  32'(bus.out_data),  32'hBEEF);
      chk("mr_post_level", 32'(bus.level),     32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
